// File: rtl/alu_proto_mon.sv
`default_nettype none
// alu_proto_mon: passive protocol and result monitor for a two-operand ALU request/response bus.
// Define ALU_MON_XCHECK_EN to build the X/Z request checker (checker 2); otherwise it is tied off.
module alu_proto_mon #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LAT    = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  opcode_valid,
  input  logic                  opcode,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow,
  input  logic                  done,
  input  logic [4:0]            checker_enable,
  output logic [4:0]            err_pulse,
  output logic [4:0]            err_sticky,
  output logic [CNT_WIDTH-1:0]  txn_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  typedef enum logic [1:0] {
    POST_RST  = 2'd0,
    IDLE      = 2'd1,
    OPB       = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Latency counter value seen on the last permitted done edge.
  localparam logic [3:0] LAT_LAST = 4'(MAX_LAT - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [1:0]            op_q, op_d;
  logic [3:0]            lat_q, lat_d;
  logic [4:0]            fail_d;
  logic                  txn_inc_d;
  logic [DATA_WIDTH:0]   exp_d;
  logic [4:0]            flag_d;
  logic [2:0]            pop_d;
  logic [CNT_WIDTH:0]    txn_sum_d;
  logic [CNT_WIDTH:0]    err_sum_d;

  logic [4:0]            err_pulse_q;
  logic [4:0]            err_sticky_q;
  logic [CNT_WIDTH-1:0]  txn_count_q;
  logic [CNT_WIDTH-1:0]  err_count_q;

  always_comb begin
    case (op_q)
      2'b00:   exp_d = {1'b0, a_q} + {1'b0, b_q};
      2'b01:   exp_d = {1'b0, a_q} - {1'b0, b_q};
      2'b10:   exp_d = {1'b0, a_q ^ b_q};
      default: exp_d = {1'b0, ~(a_q ^ b_q)};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    lat_d     = lat_q;
    fail_d    = '0;
    txn_inc_d = 1'b0;

    case (state_q)
      POST_RST: begin
        if ((result != '0) || overflow || done) fail_d[0] = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        if (done) fail_d[2] = 1'b1;
        if (opcode_valid) begin
          a_d     = data;
          op_d    = {1'b0, opcode};
          state_d = OPB;
        end
      end
      OPB: begin
        if (done) fail_d[2] = 1'b1;
        if (opcode_valid) begin
          b_d     = data;
          op_d[1] = opcode;
          lat_d   = '0;
          state_d = WAIT_DONE;
        end
      end
      default: begin
        lat_d = lat_q + 4'd1;
        if (done) begin
          txn_inc_d = 1'b1;
          if (result != exp_d[DATA_WIDTH-1:0]) fail_d[3] = 1'b1;
          if (overflow != exp_d[DATA_WIDTH])   fail_d[4] = 1'b1;
          state_d = IDLE;
          if (opcode_valid) begin
            a_d     = data;
            op_d    = {1'b0, opcode};
            state_d = OPB;
          end
        end else if (opcode_valid) begin
          // A new request while still waiting aborts the outstanding one.
          fail_d[2] = 1'b1;
          a_d       = data;
          op_d      = {1'b0, opcode};
          state_d   = OPB;
        end else if (lat_q == LAT_LAST) begin
          fail_d[2] = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase

`ifdef ALU_MON_XCHECK_EN
    if (opcode_valid && $isunknown({opcode, data})) fail_d[1] = 1'b1;
`endif
  end

  assign flag_d    = fail_d & checker_enable;
  assign pop_d     = {2'b00, flag_d[0]} + {2'b00, flag_d[1]} + {2'b00, flag_d[2]}
                   + {2'b00, flag_d[3]} + {2'b00, flag_d[4]};
  assign txn_sum_d = {1'b0, txn_count_q} + {{CNT_WIDTH{1'b0}}, txn_inc_d};
  assign err_sum_d = {1'b0, err_count_q} + {{(CNT_WIDTH-2){1'b0}}, pop_d};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= POST_RST;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      lat_q        <= '0;
      err_pulse_q  <= '0;
      err_sticky_q <= '0;
      txn_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      lat_q        <= lat_d;
      err_pulse_q  <= flag_d;
      err_sticky_q <= err_sticky_q | flag_d;
      txn_count_q  <= txn_sum_d[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : txn_sum_d[CNT_WIDTH-1:0];
      err_count_q  <= err_sum_d[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : err_sum_d[CNT_WIDTH-1:0];
    end
  end

  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign txn_count  = txn_count_q;
  assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_proto_mon.sv
`default_nettype none
// tb_alu_proto_mon: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_alu_proto_mon;
  localparam int DW      = 8;
  localparam int MAX_LAT = 2;
  localparam int CW      = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          opcode_valid, opcode, overflow, done;
  logic [DW-1:0] data, result;
  logic [4:0]    checker_enable;
  logic [4:0]    err_pulse, err_sticky;
  logic [CW-1:0] txn_count, err_count;

  int n_checks = 0;
  int n_pass   = 0;

  alu_proto_mon #(.DATA_WIDTH(DW), .MAX_LAT(MAX_LAT), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .opcode_valid(opcode_valid), .opcode(opcode),
    .data(data), .result(result), .overflow(overflow), .done(done),
    .checker_enable(checker_enable), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Transaction-level reference: what the monitor has seen so far of the current request.
  bit         m_chk_due, m_have_a, m_wait;
  int         m_age, m_a, m_b, m_opa, m_opb;
  logic [4:0] m_pulse, m_sticky;
  int         m_txn, m_err;

  task automatic model_reset();
    m_chk_due = 1; m_have_a = 0; m_wait = 0; m_age = 0;
    m_a = 0; m_b = 0; m_opa = 0; m_opb = 0;
    m_pulse = 0; m_sticky = 0; m_txn = 0; m_err = 0;
  endtask

  task automatic model_expect(output int r, output int c);
    case ({m_opb[0], m_opa[0]})
      2'b00: begin r = (m_a + m_b) % 256; c = (m_a + m_b) / 256; end
      2'b01: begin r = (m_a - m_b) & 255; c = (m_a < m_b) ? 1 : 0; end
      2'b10: begin r = m_a ^ m_b;         c = 0; end
      default: begin r = (~(m_a ^ m_b)) & 255; c = 0; end
    endcase
  endtask

  task automatic model_new_a();
    m_a = int'(data); m_opa = int'(opcode); m_have_a = 1;
  endtask

  task automatic model_edge();
    logic [4:0] f;
    int r, c;
    f = 0;
    if (m_chk_due) begin
      if (result != 0 || overflow || done) f[0] = 1;
      m_chk_due = 0;
    end else if (m_wait) begin
      m_age++;
      if (done) begin
        model_expect(r, c);
        if (int'(result) != r)   f[3] = 1;
        if (int'(overflow) != c) f[4] = 1;
        m_txn++;
        m_wait = 0;
        if (opcode_valid) model_new_a();
      end else if (opcode_valid) begin
        f[2] = 1; m_wait = 0; model_new_a();
      end else if (m_age == MAX_LAT) begin
        f[2] = 1; m_wait = 0;
      end
    end else begin
      if (done) f[2] = 1;
      if (opcode_valid) begin
        if (!m_have_a) model_new_a();
        else begin
          m_b = int'(data); m_opb = int'(opcode);
          m_have_a = 0; m_wait = 1; m_age = 0;
        end
      end
    end
`ifdef ALU_MON_XCHECK_EN
    if (opcode_valid && $isunknown({opcode, data})) f[1] = 1;
`endif
    f = f & checker_enable;
    m_pulse  = f;
    m_sticky = m_sticky | f;
    m_err    = m_err + $countones(f);
    if (m_err > 65535) m_err = 65535;
    if (m_txn > 65535) m_txn = 65535;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pulse",  32'(err_pulse),  32'(m_pulse));
    check("sticky", 32'(err_sticky), 32'(m_sticky));
    check("txn",    32'(txn_count),  32'(m_txn));
    check("errcnt", 32'(err_count),  32'(m_err));
  endtask

  task automatic drive(input logic ov, input logic opc, input logic [DW-1:0] d,
                       input logic [DW-1:0] r, input logic ovf, input logic dn);
    opcode_valid = ov; opcode = opc; data = d; result = r; overflow = ovf; done = dn;
    step();
  endtask

  task automatic idle_bus();
    opcode_valid = 0; opcode = 0; data = 0; result = 0; overflow = 0; done = 0;
  endtask

  task automatic do_reset();
    #1 reset_n = 0;
    #1;
    check("rst_pulse",  32'(err_pulse),  32'h0);
    check("rst_sticky", 32'(err_sticky), 32'h0);
    check("rst_txn",    32'(txn_count),  32'h0);
    check("rst_errcnt", 32'(err_count),  32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    idle_bus();
    checker_enable = 5'h1F;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Clean reset release.
    step();
    check("r031_sticky", 32'(err_sticky), 32'h0);
    check("r031_errcnt", 32'(err_count),  32'h0);

    // F0 + 20 -> 10 with carry, done on the second wait edge.
    drive(1, 0, 8'hF0, 0, 0, 0);
    drive(1, 0, 8'h20, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 8'h10, 1, 1);
    check("r032_pulse", 32'(err_pulse), 32'h0);
    check("r032_txn",   32'(txn_count), 32'h1);

    // 05 - 07 -> FE with borrow; overflow reported wrong.
    do_reset(); idle_bus(); step();
    drive(1, 1, 8'h05, 0, 0, 0);
    drive(1, 0, 8'h07, 0, 0, 0);
    drive(0, 0, 0, 8'hFE, 0, 1);
    check("r033_pulse",  32'(err_pulse), 32'h10);
    check("r033_errcnt", 32'(err_count), 32'h1);
    idle_bus(); step();
    check("r033_pulse_gone", 32'(err_pulse), 32'h0);

    // Done withheld past MAX_LAT, then a late spurious done.
    do_reset(); idle_bus(); step();
    drive(1, 0, 8'h11, 0, 0, 0);
    drive(1, 1, 8'h22, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("r034_timeout", 32'(err_pulse), 32'h4);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 8'h33, 0, 1);
    check("r034_spurious", 32'(err_pulse), 32'h4);
    check("r034_errcnt",   32'(err_count), 32'h2);

    // Disabled checker must stay silent.
    do_reset(); idle_bus(); checker_enable = 5'h0B; step();
    drive(0, 0, 0, 0, 0, 1);
    check("en_masked", 32'(err_pulse), 32'h0);
    checker_enable = 5'h1F;

    // X on the request data.
    do_reset(); idle_bus(); step();
    opcode_valid = 1; opcode = 0; data = 'x; result = 0; overflow = 0; done = 0;
    @(posedge clk); #1;
    idle_bus(); step();
`ifdef ALU_MON_XCHECK_EN
    check("r035_xsticky", 32'(err_sticky[1]), 32'h1);
`else
    check("r035_xsticky", 32'(err_sticky[1]), 32'h0);
`endif

    // Asynchronous reset in the middle of a wait.
    do_reset(); idle_bus(); step();
    drive(1, 0, 8'h01, 0, 0, 0);
    drive(1, 0, 8'h02, 0, 0, 0);
    drive(0, 0, 0, 8'h03, 0, 1);
    check("r036_pre_txn", 32'(txn_count), 32'h1);
    drive(1, 1, 8'h09, 0, 0, 0);
    drive(1, 0, 8'h04, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    do_reset(); idle_bus();
    repeat (4) step();
    check("r036_sticky", 32'(err_sticky), 32'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      int r, c;
      if (i % 150 == 149) begin
        do_reset();
        result = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        overflow = ($urandom_range(0, 5) == 0);
        done = ($urandom_range(0, 5) == 0);
        opcode_valid = 0;
        step();
        continue;
      end
      checker_enable = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F;
      opcode_valid = ($urandom_range(0, 9) < 4);
      opcode = 1'($urandom);
      data = 8'($urandom);
      done = m_wait ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 19) == 0);
      model_expect(r, c);
      if (m_wait && $urandom_range(0, 3) != 0) begin
        result = 8'(r); overflow = 1'(c);
      end else begin
        result = 8'($urandom); overflow = 1'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_proto_mon.md
ALU_PROTO_MON -- requirements
Module: alu_proto_mon

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/result width.
REQ-002 SHALL have parameter MAX_LAT, default 2, max cycles from operand-B capture to done (legal 1..15).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of both counters.
REQ-004 SHALL have port clk  input  1  sole clock; all logic samples on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports opcode_valid  input  1, opcode  input  1, data  input  DATA_WIDTH: observed ALU request bus.
REQ-007 SHALL have ports result  input  DATA_WIDTH, overflow  input  1, done  input  1: observed ALU response.
REQ-008 SHALL have port checker_enable  input  5  per-checker enable, bit k enables checker k+1.
REQ-009 SHALL have port err_pulse  output  5  one-cycle registered failure strobe per checker.
REQ-010 SHALL have port err_sticky  output  5  latched failure per checker.
REQ-011 SHALL have ports txn_count and err_count  output  CNT_WIDTH: completed transactions, total failures.

Function
REQ-012 SHALL track transactions with FSM states POST_RST, IDLE, OPB, WAIT_DONE; tracking runs regardless of checker_enable.
REQ-013 POST_RST: at first edge with reset_n high, checker 1 SHALL fail if result!=0, overflow!=0 or done!=0; then go IDLE.
REQ-014 IDLE: opcode_valid high SHALL capture A=data, op[0]=opcode, go OPB.
REQ-015 OPB: opcode_valid high SHALL capture B=data, op[1]=opcode, clear latency counter, go WAIT_DONE.
REQ-016 Checker 2 SHALL fail on any edge where opcode_valid=1 and opcode or data contains X/Z (see REQ-030).
REQ-017 WAIT_DONE: latency counter SHALL increment each edge; done high at edge 1..MAX_LAT after B capture completes the transaction; no done by edge MAX_LAT SHALL fail checker 3 and return IDLE.
REQ-018 Expected value SHALL be computed at DATA_WIDTH+1 bits: op 00 A+B, 01 A-B, 10 A^B, 11 ~(A^B) on low DATA_WIDTH bits.
REQ-019 On done, checker 4 SHALL fail if result != expected[DATA_WIDTH-1:0].
REQ-020 On done, checker 5 SHALL fail if overflow != expected bit DATA_WIDTH for ops 00/01 (carry/borrow), or != 0 for ops 10/11.
REQ-021 done high in IDLE or OPB SHALL fail checker 3 (spurious done); state unchanged.
REQ-022 opcode_valid high in WAIT_DONE without done SHALL fail checker 3, abort transaction, capture data as new A, go OPB.
REQ-023 done and opcode_valid on same edge in WAIT_DONE SHALL complete the transaction, then capture new A, go OPB.
REQ-024 A checker SHALL only flag when its checker_enable bit is 1 on the evaluating edge.
REQ-025 err_pulse[k] SHALL be high exactly the cycle after a failure edge; err_sticky[k] SHALL set with it and hold until reset.
REQ-026 txn_count SHALL increment per completed (done-seen) transaction; err_count SHALL add the number of err_pulse bits set; both saturate at all-ones.

Reset
REQ-027 reset_n low SHALL immediately force FSM to POST_RST, and err_pulse, err_sticky, txn_count, err_count, captured A/B/op and latency counter to 0.
REQ-028 Reset asserted mid-transaction SHALL discard it without flagging any checker.
REQ-029 Checker 1 SHALL evaluate only once per reset release.

Configuration
REQ-030 Macro ALU_MON_XCHECK_EN defined: checker 2 active per REQ-016; undefined: checker 2 logic absent, err_pulse[1] and err_sticky[1] tied 0.

Verification
REQ-031 Reset release with result=0, overflow=0, done=0, enable=5'h1F -> err_sticky=0, err_count=0.
REQ-032 A=8'hF0 op0=0, B=8'h20 op1=0, done at 2nd edge with result=8'h10, overflow=1 -> no errors, txn_count=1.
REQ-033 A=8'h05, B=8'h07, op=01, done with result=8'hFE, overflow=0 -> err_pulse=5'b10000 one cycle, err_count=1.
REQ-034 MAX_LAT=2, B captured, done withheld 3 edges -> err_pulse[2]=1, FSM IDLE; later done -> err_pulse[2] again, err_count=2.
REQ-035 opcode_valid=1 with data=8'hXX, macro defined, enable[1]=1 -> err_sticky[1]=1; macro undefined -> err_sticky[1]=0.
REQ-036 reset_n low during WAIT_DONE -> all outputs 0 same cycle, no checker flags after release.
